karatsuba_acc: RTL and testbench

//  Downstream consumer of the 8x8 Karatsuba multiplier: takes its 16-bit product Z each

---
 rtl/kamasutra_pkg.sv | 14 +
 rtl/karatsuba_acc.sv | 103 ++++++++++
 tb/tb_karatsuba_acc.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/kamasutra_pkg.sv
// Shared definitions for the Karatsuba multiplier and its dot-product accumulator.
package kamasutra_pkg;

  // Product width of the 8x8 multiplier (Z output); the accumulator's default input width.
  localparam int unsigned DEFAULT_PROD_W = 16;

  // Accumulator sum state: no sum open, sum open, result held.
  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } acc_state_t;

endpackage

// File: rtl/karatsuba_acc.sv
// Dot-product accumulator fed by the Karatsuba multiplier product over valid/ready.
// A term with in_last set, or the MAX_TERMS-th term, closes the sum, which is then
// held on out_* until accepted. A new sum may start in the cycle the result is taken.
// Optional build macro: ACC_SAT_EN (saturate acc on carry instead of wrapping).
module karatsuba_acc
  import kamasutra_pkg::*;
#(
  parameter int unsigned PROD_W    = DEFAULT_PROD_W,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned MAX_TERMS = 256,
  localparam int unsigned CNT_W    = $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_terms,
  output logic              out_ovf
);

  localparam int unsigned SUM_W = ACC_W + 1;

  acc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             in_xfer;
  logic             out_xfer;
  logic             first_term;
  logic [SUM_W-1:0] sum_ext;
  logic [ACC_W-1:0] acc_n;
  logic [CNT_W-1:0] cnt_n;
  logic             ovf_n;
  logic             closing;

  // Only comb path to an output: in_ready from out_ready while a result is held.
  assign in_ready = (state != DONE) || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Next accumulator values for an accepted term; only applied on in_xfer.
  always_comb begin
    first_term = (state != ACC);
    sum_ext    = SUM_W'(acc) + SUM_W'(in_prod);
    acc_n      = '0;
    cnt_n      = '0;
    ovf_n      = 1'b0;
    if (first_term) begin
      acc_n = ACC_W'(in_prod);
      cnt_n = CNT_W'(1);
      ovf_n = 1'b0;
    end else begin
      cnt_n = cnt + CNT_W'(1);
      ovf_n = ovf | sum_ext[ACC_W];
`ifdef ACC_SAT_EN
      // Once any carry has occurred the sum stays pinned at all-ones.
      acc_n = ovf_n ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
      acc_n = sum_ext[ACC_W-1:0];
`endif
    end
    closing = in_last || (cnt_n == CNT_W'(MAX_TERMS));
  end

  // FSM, accumulator and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_terms <= '0;
      out_ovf   <= 1'b0;
    end else if (in_xfer) begin
      // In DONE an input transfer implies the output transfer too.
      acc <= acc_n;
      cnt <= cnt_n;
      ovf <= ovf_n;
      if (closing) begin
        state     <= DONE;
        out_valid <= 1'b1;
        out_sum   <= acc_n;
        out_terms <= cnt_n;
        out_ovf   <= ovf_n;
      end else begin
        state     <= ACC;
        out_valid <= 1'b0;
      end
    end else if (out_xfer) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_karatsuba_acc.sv
// Directed, table-driven bench for karatsuba_acc: a default instance, an ACC_W=17
// instance for overflow, and a MAX_TERMS=4 instance for forced close.
module tb_karatsuba_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic        m_in_ready, m_out_valid, m_out_ovf;
  logic [23:0] m_out_sum;
  logic [8:0]  m_out_terms;

  logic        w_in_ready, w_out_valid, w_out_ovf;
  logic [16:0] w_out_sum;
  logic [8:0]  w_out_terms;

  logic        t_in_ready, t_out_valid, t_out_ovf;
  logic [23:0] t_out_sum;
  logic [2:0]  t_out_terms;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  karatsuba_acc u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_sum(m_out_sum), .out_terms(m_out_terms), .out_ovf(m_out_ovf)
  );

  karatsuba_acc #(.ACC_W(17)) u_w17 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_sum(w_out_sum), .out_terms(w_out_terms), .out_ovf(w_out_ovf)
  );

  karatsuba_acc #(.MAX_TERMS(4)) u_t4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(t_out_valid), .out_ready(out_ready),
    .out_sum(t_out_sum), .out_terms(t_out_terms), .out_ovf(t_out_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge.
  task automatic drive(input logic v, input logic [15:0] p, input logic l, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_prod   = p;
    in_last   = l;
    out_ready = r;
  endtask

  task automatic do_reset();
    drive(1'b1, 16'hffff, 1'b1, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] p;
    logic        l;
    logic        r;
    logic        e_ir;
    logic        e_ov;
    logic [23:0] e_sum;
    logic [8:0]  e_terms;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[15];

  logic [16:0] exp_w_sum;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;

    // Observations are taken before the edge that applies each row's inputs.
    tbl[0]  = '{1'b1, 16'd6,     1'b0, 1'b1, 1'b1, 1'b0, 24'd0,     9'd0, 1'b0};
    tbl[1]  = '{1'b1, 16'd35,    1'b0, 1'b1, 1'b1, 1'b0, 24'd0,     9'd0, 1'b0};
    tbl[2]  = '{1'b1, 16'd65025, 1'b1, 1'b1, 1'b1, 1'b0, 24'd0,     9'd0, 1'b0};
    tbl[3]  = '{1'b0, 16'd0,     1'b0, 1'b1, 1'b1, 1'b1, 24'd65066, 9'd3, 1'b0};
    tbl[4]  = '{1'b0, 16'd0,     1'b0, 1'b1, 1'b1, 1'b0, 24'd0,     9'd0, 1'b0};
    tbl[5]  = '{1'b1, 16'd100,   1'b1, 1'b0, 1'b1, 1'b0, 24'd0,     9'd0, 1'b0};
    tbl[6]  = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b0, 1'b1, 24'd100,   9'd1, 1'b0};
    tbl[7]  = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b0, 1'b1, 24'd100,   9'd1, 1'b0};
    tbl[8]  = '{1'b1, 16'd999,   1'b1, 1'b0, 1'b0, 1'b1, 24'd100,   9'd1, 1'b0};
    tbl[9]  = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b0, 1'b1, 24'd100,   9'd1, 1'b0};
    tbl[10] = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b0, 1'b1, 24'd100,   9'd1, 1'b0};
    tbl[11] = '{1'b1, 16'd7,     1'b1, 1'b1, 1'b1, 1'b1, 24'd100,   9'd1, 1'b0};
    tbl[12] = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b0, 1'b1, 24'd7,     9'd1, 1'b0};
    tbl[13] = '{1'b0, 16'd0,     1'b0, 1'b1, 1'b1, 1'b1, 24'd7,     9'd1, 1'b0};
    tbl[14] = '{1'b0, 16'd0,     1'b0, 1'b1, 1'b1, 1'b0, 24'd0,     9'd0, 1'b0};

    // Reset held two cycles with in_valid high.
    do_reset();
    check("reset out_valid", 32'(m_out_valid), 32'd0);
    check("reset in_ready",  32'(m_in_ready),  32'd1);
    check("reset out_sum",   32'(m_out_sum),   32'd0);
    check("reset out_terms", 32'(m_out_terms), 32'd0);
    check("reset out_ovf",   32'(m_out_ovf),   32'd0);

    // 3-term sum, then backpressure and a back-to-back sum.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].p, tbl[i].l, tbl[i].r);
      #1;
      check($sformatf("row%0d in_ready", i),  32'(m_in_ready),  32'(tbl[i].e_ir));
      check($sformatf("row%0d out_valid", i), 32'(m_out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        check($sformatf("row%0d out_sum", i),   32'(m_out_sum),   32'(tbl[i].e_sum));
        check($sformatf("row%0d out_terms", i), 32'(m_out_terms), 32'(tbl[i].e_terms));
        check($sformatf("row%0d out_ovf", i),   32'(m_out_ovf),   32'(tbl[i].e_ovf));
      end
    end

    // Overflow on a 17-bit accumulator: 3 x 65025 = 195075.
    do_reset();
    drive(1'b1, 16'd65025, 1'b0, 1'b1);
    drive(1'b1, 16'd65025, 1'b0, 1'b1);
    drive(1'b1, 16'd65025, 1'b1, 1'b1);
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    #1;
`ifdef ACC_SAT_EN
    exp_w_sum = 17'd131071;
`else
    exp_w_sum = 17'd64003;
`endif
    check("w17 out_valid", 32'(w_out_valid), 32'd1);
    check("w17 out_sum",   32'(w_out_sum),   32'(exp_w_sum));
    check("w17 out_terms", 32'(w_out_terms), 32'd3);
    check("w17 out_ovf",   32'(w_out_ovf),   32'd1);

    // Forced close at MAX_TERMS=4, then the next term opens a new sum.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 16'd1, 1'b0, 1'b0);
    drive(1'b1, 16'd1, 1'b0, 1'b1);
    #1;
    check("t4 no early close", 32'(t_out_valid), 32'd0);
    drive(1'b1, 16'd5, 1'b0, 1'b1);
    #1;
    check("t4 forced valid", 32'(t_out_valid), 32'd1);
    check("t4 forced sum",   32'(t_out_sum),   32'd4);
    check("t4 forced terms", 32'(t_out_terms), 32'd4);
    check("t4 forced ovf",   32'(t_out_ovf),   32'd0);
    drive(1'b1, 16'd2, 1'b1, 1'b1);
    #1;
    check("t4 new sum open", 32'(t_out_valid), 32'd0);
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    #1;
    check("t4 second valid", 32'(t_out_valid), 32'd1);
    check("t4 second sum",   32'(t_out_sum),   32'd7);
    check("t4 second terms", 32'(t_out_terms), 32'd2);

    // Reset mid-sum discards the partial sum.
    do_reset();
    drive(1'b1, 16'd10, 1'b0, 1'b1);
    drive(1'b1, 16'd20, 1'b0, 1'b1);
    do_reset();
    check("midrst out_valid", 32'(m_out_valid), 32'd0);
    drive(1'b1, 16'd9, 1'b1, 1'b1);
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    #1;
    check("midrst valid", 32'(m_out_valid), 32'd1);
    check("midrst sum",   32'(m_out_sum),   32'd9);
    check("midrst terms", 32'(m_out_terms), 32'd1);
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    #1;
    check("midrst single result", 32'(m_out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
